gpr_mp: RTL and testbench

GPR_MP -- requirements
Module: gpr_mp

---
 rtl/gpr_mp_if.sv | 31 +++
 rtl/gpr_mp.sv | 87 ++++++++
 tb/tb_gpr_mp.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_mp_if.sv
// Bus bundle for the general-purpose register file: read ports, write ports,
// issue/flush scoreboard controls and the pending-count output.
interface gpr_mp_if #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned NREG = 32,
   parameter int unsigned NRD  = 2,
   parameter int unsigned NWR  = 2
);
   localparam int unsigned AW = $clog2(NREG);

   logic [NRD*AW-1:0]   rs_idx;
   logic [NRD*XLEN-1:0] rs_data;
   logic [NRD-1:0]      rs_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_idx;
   logic [NWR*XLEN-1:0] wr_data;
   logic                issue_en;
   logic [AW-1:0]       issue_rd;
   logic                flush;
   logic [AW:0]         busy_cnt;

   modport master (
      output rs_idx, wr_en, wr_idx, wr_data, issue_en, issue_rd, flush,
      input  rs_data, rs_busy, busy_cnt
   );

   modport slave (
      input  rs_idx, wr_en, wr_idx, wr_data, issue_en, issue_rd, flush,
      output rs_data, rs_busy, busy_cnt
   );
endinterface

// File: rtl/gpr_mp.sv
// Multi-ported register file with a per-register pending scoreboard; register 0
// is hardwired to zero and reads optionally forward same-cycle writes.
module gpr_mp #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned NREG   = 32,
   parameter int unsigned NRD    = 2,
   parameter int unsigned NWR    = 2,
   parameter int unsigned BYPASS = 1
) (
   input  logic      clk,
   input  logic      rst,
   gpr_mp_if.slave   bus_io
);
   localparam int unsigned AW = $clog2(NREG);
   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] pending_q, pending_d;
   logic [CW-1:0]   busy_cnt_q, busy_cnt_d;

   // Next pending vector: write clears, then issue sets, then flush wipes all.
   always_comb begin : pend_next
      pending_d = pending_q;
      for (int i = 0; i < int'(NWR); i++) begin
         if (bus_io.wr_en[i]) pending_d[bus_io.wr_idx[i*AW +: AW]] = 1'b0;
      end
      if (bus_io.issue_en) pending_d[bus_io.issue_rd] = 1'b1;
      if (bus_io.flush) pending_d = '0;
      pending_d[0] = 1'b0;
   end

   always_comb begin : cnt_next
      busy_cnt_d = '0;
      for (int r = 0; r < int'(NREG); r++) begin
         busy_cnt_d = busy_cnt_d + CW'(pending_d[r]);
      end
   end

   // Later write ports are assigned last, so they win on index collisions.
   always_ff @(posedge clk) begin : state_reg
      if (rst) begin
         for (int r = 0; r < int'(NREG); r++) regs_q[r] <= '0;
         pending_q  <= '0;
         busy_cnt_q <= '0;
      end else begin
         for (int i = 0; i < int'(NWR); i++) begin
            if (bus_io.wr_en[i] && (bus_io.wr_idx[i*AW +: AW] != '0)) begin
               regs_q[bus_io.wr_idx[i*AW +: AW]] <= bus_io.wr_data[i*XLEN +: XLEN];
            end
         end
         pending_q  <= pending_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   // Zero-latency read ports with optional same-cycle forwarding.
   always_comb begin : read_ports
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] data;
      logic            hit;
      idx             = '0;
      data            = '0;
      hit             = 1'b0;
      bus_io.rs_data  = '0;
      bus_io.rs_busy  = '0;
      for (int j = 0; j < int'(NRD); j++) begin
         idx  = bus_io.rs_idx[j*AW +: AW];
         data = regs_q[idx];
         hit  = 1'b0;
         if (BYPASS != 0) begin
            for (int i = 0; i < int'(NWR); i++) begin
               if (bus_io.wr_en[i] && (bus_io.wr_idx[i*AW +: AW] == idx)) begin
                  data = bus_io.wr_data[i*XLEN +: XLEN];
                  hit  = 1'b1;
               end
            end
         end
         if (idx != '0) begin
            bus_io.rs_data[j*XLEN +: XLEN] = data;
            bus_io.rs_busy[j]              = pending_q[idx] & ~hit;
         end
      end
   end

   assign bus_io.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: a forwarding and a non-forwarding instance share stimulus
// and are checked each cycle against an array/bitmask model plus literal values.
module tb_gpr_mp;
   localparam int unsigned XLEN = 64;
   localparam int unsigned NREG = 32;
   localparam int unsigned NRD  = 2;
   localparam int unsigned NWR  = 2;
   localparam int unsigned AW   = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   chk_en = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   gpr_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus_a ();
   gpr_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus_b ();

   gpr_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut_a (
      .clk(clk), .rst(rst), .bus_io(bus_a.slave));
   gpr_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_b (
      .clk(clk), .rst(rst), .bus_io(bus_b.slave));

   assign bus_b.rs_idx   = bus_a.rs_idx;
   assign bus_b.wr_en    = bus_a.wr_en;
   assign bus_b.wr_idx   = bus_a.wr_idx;
   assign bus_b.wr_data  = bus_a.wr_data;
   assign bus_b.issue_en = bus_a.issue_en;
   assign bus_b.issue_rd = bus_a.issue_rd;
   assign bus_b.flush    = bus_a.flush;

   always #5 clk = ~clk;

   // Model state: architectural values and a pending bitmask.
   logic [XLEN-1:0] mem [NREG];
   logic [NREG-1:0] pend_m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic match_wr(input int i, input logic [AW-1:0] idx);
      return bus_a.wr_en[i] && (bus_a.wr_idx[i*AW +: AW] == idx);
   endfunction

   // Highest-numbered matching write port supplies forwarded data.
   function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] idx, input bit byp);
      if (idx == 0) return '0;
      if (byp) begin
         for (int i = NWR - 1; i >= 0; i--) begin
            if (match_wr(i, idx)) return bus_a.wr_data[i*XLEN +: XLEN];
         end
      end
      return mem[idx];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] idx, input bit byp);
      if (idx == 0) return 1'b0;
      if (byp) begin
         for (int i = 0; i < NWR; i++) if (match_wr(i, idx)) return 1'b0;
      end
      return pend_m[idx];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) mem[r] = '0;
         pend_m = '0;
      end else begin
         for (int i = 0; i < NWR; i++) begin
            if (bus_a.wr_en[i] && bus_a.wr_idx[i*AW +: AW] != 0) begin
               mem[bus_a.wr_idx[i*AW +: AW]]    = bus_a.wr_data[i*XLEN +: XLEN];
               pend_m[bus_a.wr_idx[i*AW +: AW]] = 1'b0;
            end
         end
         if (bus_a.flush) pend_m = '0;
         else if (bus_a.issue_en && bus_a.issue_rd != 0) pend_m[bus_a.issue_rd] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int j = 0; j < NRD; j++) begin
            logic [AW-1:0] idx;
            idx = bus_a.rs_idx[j*AW +: AW];
            chk($sformatf("a.rs_data[%0d]", j), bus_a.rs_data[j*XLEN +: XLEN], exp_data(idx, 1'b1));
            chk($sformatf("b.rs_data[%0d]", j), bus_b.rs_data[j*XLEN +: XLEN], exp_data(idx, 1'b0));
            chk($sformatf("a.rs_busy[%0d]", j), 64'(bus_a.rs_busy[j]), 64'(exp_busy(idx, 1'b1)));
            chk($sformatf("b.rs_busy[%0d]", j), 64'(bus_b.rs_busy[j]), 64'(exp_busy(idx, 1'b0)));
         end
         chk("a.busy_cnt", 64'(bus_a.busy_cnt), 64'($countones(pend_m)));
         chk("b.busy_cnt", 64'(bus_b.busy_cnt), 64'($countones(pend_m)));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rs(input int j, input int idx);
      bus_a.rs_idx[j*AW +: AW] = AW'(idx);
   endtask

   task automatic set_wr(input int i, input bit en, input int idx, input logic [XLEN-1:0] d);
      bus_a.wr_en[i]               = en;
      bus_a.wr_idx[i*AW +: AW]     = AW'(idx);
      bus_a.wr_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic issue(input bit en, input int rd);
      bus_a.issue_en = en;
      bus_a.issue_rd = AW'(rd);
   endtask

   task automatic clr_in();
      bus_a.wr_en   = '0;
      bus_a.wr_idx  = '0;
      bus_a.wr_data = '0;
      bus_a.flush   = 1'b0;
      issue(1'b0, 0);
   endtask

   function automatic logic [XLEN-1:0] rd_a(input int j);
      return bus_a.rs_data[j*XLEN +: XLEN];
   endfunction

   function automatic logic [XLEN-1:0] rd_b(input int j);
      return bus_b.rs_data[j*XLEN +: XLEN];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_in();
      bus_a.rs_idx = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk_en = 1'b1;

      // Every index reads zero and idle after reset.
      for (int idx = 0; idx < NREG; idx++) begin
         set_rs(0, idx);
         set_rs(1, NREG - 1 - idx);
         @(negedge clk);
         chk("rst_data", rd_a(0) | rd_a(1) | rd_b(0) | rd_b(1), 64'h0);
         chk("rst_busy", 64'(bus_a.rs_busy | bus_b.rs_busy), 64'h0);
         chk("rst_cnt", 64'(bus_a.busy_cnt), 64'h0);
         #1;
      end

      // Dual write to one index: higher port wins.
      step();
      set_wr(0, 1'b1, 5, 64'hDEAD);
      set_wr(1, 1'b1, 5, 64'hBEEF);
      set_rs(0, 5);
      set_rs(1, 0);
      @(negedge clk);
      chk("dual_fwd_a", rd_a(0), 64'hBEEF);
      chk("dual_fwd_b", rd_b(0), 64'h0);
      step();
      clr_in();
      @(negedge clk);
      chk("dual_next_a", rd_a(0), 64'hBEEF);
      chk("dual_next_b", rd_b(0), 64'hBEEF);

      // Register 0 ignores writes and issues.
      step();
      set_wr(0, 1'b1, 0, 64'h1234);
      issue(1'b1, 0);
      set_rs(0, 0);
      @(negedge clk);
      chk("r0_data", rd_a(0), 64'h0);
      chk("r0_busy", 64'(bus_a.rs_busy[0]), 64'h0);
      step();
      clr_in();
      @(negedge clk);
      chk("r0_data_next", rd_a(0) | rd_b(0), 64'h0);
      chk("r0_cnt", 64'(bus_a.busy_cnt), 64'h0);

      // Issue then write+issue on the same register.
      step();
      issue(1'b1, 7);
      set_rs(0, 7);
      step();
      clr_in();
      @(negedge clk);
      chk("iss7_busy", 64'(bus_a.rs_busy[0]), 64'h1);
      chk("iss7_cnt", 64'(bus_a.busy_cnt), 64'h1);
      step();
      set_wr(0, 1'b1, 7, 64'h55);
      issue(1'b1, 7);
      @(negedge clk);
      chk("wi7_busy_a", 64'(bus_a.rs_busy[0]), 64'h0);
      chk("wi7_busy_b", 64'(bus_b.rs_busy[0]), 64'h1);
      chk("wi7_data_a", rd_a(0), 64'h55);
      step();
      clr_in();
      @(negedge clk);
      chk("wi7_busy_next", 64'(bus_a.rs_busy[0]), 64'h1);
      chk("wi7_cnt", 64'(bus_a.busy_cnt), 64'h1);
      chk("wi7_data_b", rd_b(0), 64'h55);

      // Three issues, then flush overriding an issue.
      step();
      bus_a.flush = 1'b1;
      step();
      clr_in();
      issue(1'b1, 3);
      step();
      issue(1'b1, 4);
      step();
      issue(1'b1, 9);
      step();
      clr_in();
      @(negedge clk);
      chk("three_cnt", 64'(bus_a.busy_cnt), 64'h3);
      step();
      bus_a.flush = 1'b1;
      issue(1'b1, 10);
      step();
      clr_in();
      set_rs(0, 3);
      set_rs(1, 10);
      @(negedge clk);
      chk("flush_cnt", 64'(bus_a.busy_cnt), 64'h0);
      chk("flush_busy", 64'(bus_a.rs_busy | bus_b.rs_busy), 64'h0);
      step();
      set_rs(0, 5);
      set_rs(1, 7);
      @(negedge clk);
      chk("flush_keep5", rd_a(0), 64'hBEEF);
      chk("flush_keep7", rd_a(1), 64'h55);

      // Mixed traffic on a small index range to force collisions.
      for (int k = 0; k < 80; k++) begin
         step();
         bus_a.wr_en   = NWR'($urandom_range(0, 3));
         for (int i = 0; i < NWR; i++) begin
            bus_a.wr_idx[i*AW +: AW]      = AW'($urandom_range(0, 7));
            bus_a.wr_data[i*XLEN +: XLEN] = {$urandom, $urandom};
         end
         issue(1'($urandom_range(0, 1)), $urandom_range(0, 7));
         bus_a.flush = ($urandom_range(0, 9) == 0);
         set_rs(0, $urandom_range(0, 7));
         set_rs(1, $urandom_range(0, 7));
      end
      step();
      clr_in();

      // Reset wins over concurrent write/issue; writes resume right after.
      step();
      set_wr(0, 1'b1, 2, 64'hAA);
      step();
      clr_in();
      rst = 1'b1;
      set_wr(0, 1'b1, 2, 64'hBB);
      issue(1'b1, 6);
      step();
      rst = 1'b0;
      clr_in();
      set_rs(0, 2);
      set_rs(1, 6);
      @(negedge clk);
      chk("rst_idx2", rd_a(0) | rd_b(0), 64'h0);
      chk("rst_cnt2", 64'(bus_a.busy_cnt), 64'h0);
      step();
      set_wr(0, 1'b1, 2, 64'h77);
      step();
      clr_in();
      @(negedge clk);
      chk("post_rst_wr", rd_b(0), 64'h77);

      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
